// File: rtl/mips_pkg.sv
// Shared loader definitions: FSM state encoding and the frame header byte.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package mips_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CHECK = 3'd6
`endif
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; last_byte flags that
// the next shifted byte completes the current word.
module imem_word_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [31:0] word_reg;
  logic [1:0]  byte_cnt_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_reg     <= '0;
      byte_cnt_reg <= '0;
    end else if (clear) begin
      word_reg     <= '0;
      byte_cnt_reg <= '0;
    end else if (shift_en) begin
      word_reg     <= {word_reg[23:0], byte_in};
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
    end
  end

  assign word      = word_reg;
  assign last_byte = (byte_cnt_reg == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot-link loader: parses A5/N/data frames into instruction-memory writes and
// releases the core on success. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import mips_pkg::*;
#(
  parameter int          MAX_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  loader_state_t    state_reg, state_next;
  logic [IDX_W-1:0] word_index_reg, word_index_next;
  logic [IDX_W-1:0] count_reg, count_next;
  logic             accept, pack_clear, pack_shift, last_byte;
  logic [31:0]      word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_reg, csum_next;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = (state_reg == IDLE) || (state_reg == COUNT) ||
                    (state_reg == DATA) || (state_reg == CHECK);
`else
  assign in_ready = (state_reg == IDLE) || (state_reg == COUNT) ||
                    (state_reg == DATA);
`endif
  assign accept = in_valid && in_ready;

  imem_word_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (pack_clear),
    .shift_en  (pack_shift),
    .byte_in   (in_data),
    .word      (word),
    .last_byte (last_byte)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      word_index_reg <= '0;
      count_reg      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg       <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      word_index_reg <= word_index_next;
      count_reg      <= count_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg       <= csum_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    word_index_next = word_index_reg;
    count_next      = count_reg;
    pack_clear      = 1'b0;
    pack_shift      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_next       = csum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (accept && in_data == HEADER_BYTE) state_next = COUNT;
      end
      COUNT: begin
        if (accept) begin
          if (in_data == 8'd0 || int'(in_data) > MAX_WORDS) begin
            state_next = ERROR;
          end else begin
            count_next      = IDX_W'(in_data);
            word_index_next = '0;
            pack_clear      = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_next       = '0;
`endif
            state_next      = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          pack_shift = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_next  = csum_reg ^ in_data;
`endif
          if (last_byte) state_next = WRITE;
        end
      end
      WRITE: begin
        // index cannot wrap: IDX_W holds MAX_WORDS itself
        word_index_next = word_index_reg + IDX_W'(1);
        if (word_index_next == count_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) state_next = (in_data == csum_reg) ? DONE : ERROR;
      end
`endif
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Write bus is zero outside WRITE so reset shows a clean all-zero bus.
  assign imem_we    = (state_reg == WRITE);
  assign imem_addr  = imem_we ? (BASE_ADDR + (32'(word_index_reg) << 2)) : 32'h0;
  assign imem_wdata = imem_we ? word : 32'h0;
  assign core_hold  = (state_reg != DONE);
  assign done       = (state_reg == DONE);
  assign error      = (state_reg == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum scenarios run only
// when IMEM_LOADER_CHECKSUM_EN is defined, and every frame carries a checksum then.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int fails  = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          cycle_cnt = 0;
  int          dbl_pulse = 0;
  logic        prev_we = 1'b0;
  logic [31:0] wv [64];

  always #5 clock = ~clock;

  imem_loader #(
    .MAX_WORDS (64),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // Write monitor: log every cycle with imem_we high, flag back-to-back pulses.
  always @(negedge clock) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cycle_cnt);
      if (prev_we) dbl_pulse <= dbl_pulse + 1;
    end
    prev_we <= imem_we;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int w;
    w = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clock);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL byte_accept: in_ready=%b required 1 for byte %h", in_ready, b);
    end
    @(negedge clock);
  endtask

  task automatic send_frame(input int n, input logic [31:0] words [64], input bit gap);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    send_byte(8'hA5, gap);
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--) begin
        b  = words[i][k*8 +: 8];
        cs = cs ^ b;
        send_byte(b, gap);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs, gap);
`endif
    in_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if (imem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b required 0", imem_we); end
    checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h required 0", imem_addr); end
    checks++; if (imem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h required 0", imem_wdata); end
    checks++; if (core_hold !== 1'b1) begin fails++; $display("FAIL reset_hold: got %b required 1", core_hold); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b required 0", error); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (in_ready !== 1'b1 || core_hold !== 1'b1) begin fails++; $display("FAIL post_reset_idle: ready=%b hold=%b required 1 1", in_ready, core_hold); end
    $display("test_reset: done");
  endtask

  task automatic test_basic_frame();
    int base, n;
    do_reset();
    base  = wr_addr.size();
    wv[0] = 32'h2008_0005;
    wv[1] = 32'hAC08_0000;
    send_frame(2, wv, 1'b0);
    settle(3);
    n = wr_addr.size() - base;
    checks++; if (n !== 2) begin fails++; $display("FAIL basic_nwrites: got %0d required 2", n); end
    if (n >= 2) begin
      checks++; if (wr_addr[base] !== 32'h0) begin fails++; $display("FAIL basic_addr0: got %h required 00000000", wr_addr[base]); end
      checks++; if (wr_data[base] !== 32'h2008_0005) begin fails++; $display("FAIL basic_data0: got %h required 20080005", wr_data[base]); end
      checks++; if (wr_addr[base+1] !== 32'h4) begin fails++; $display("FAIL basic_addr1: got %h required 00000004", wr_addr[base+1]); end
      checks++; if (wr_data[base+1] !== 32'hAC08_0000) begin fails++; $display("FAIL basic_data1: got %h required ac080000", wr_data[base+1]); end
      checks++; if (wr_cyc[base+1] - wr_cyc[base] !== 5) begin fails++; $display("FAIL basic_word_rate: got %0d cycles required 5", wr_cyc[base+1] - wr_cyc[base]); end
    end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL basic_done: got %b required 1", done); end
    checks++; if (core_hold !== 1'b0) begin fails++; $display("FAIL basic_hold: got %b required 0", core_hold); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL basic_error: got %b required 0", error); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_done: got %b required 0", in_ready); end
    // DONE must ignore further traffic, including a new header.
    base     = wr_addr.size();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    repeat (6) @(negedge clock);
    settle(2);
    checks++; if (wr_addr.size() - base !== 0 || done !== 1'b1) begin fails++; $display("FAIL done_ignore: writes=%0d done=%b required 0 1", wr_addr.size() - base, done); end
    $display("test_basic_frame: writes=%0d done=%b hold=%b", n, done, core_hold);
  endtask

  task automatic test_discard();
    int base, n;
    do_reset();
    base = wr_addr.size();
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    settle(2);
    checks++; if (wr_addr.size() - base !== 0) begin fails++; $display("FAIL discard_nowrite: got %0d required 0", wr_addr.size() - base); end
    checks++; if (in_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL discard_idle: ready=%b done=%b error=%b required 1 0 0", in_ready, done, error); end
    wv[0] = 32'hDEAD_BEEF;
    send_frame(1, wv, 1'b0);
    settle(3);
    n = wr_addr.size() - base;
    checks++; if (n !== 1) begin fails++; $display("FAIL discard_nwrites: got %0d required 1", n); end
    if (n >= 1) begin
      checks++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL discard_write: got %h/%h required 00000000/deadbeef", wr_addr[base], wr_data[base]); end
    end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL discard_done: got %b required 1", done); end
    $display("test_discard: writes=%0d done=%b", n, done);
  endtask

  task automatic test_bad_count();
    int base;
    do_reset();
    base = wr_addr.size();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    settle(3);
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL count0_error: got %b required 1", error); end
    checks++; if (core_hold !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL count0_hold: hold=%b done=%b required 1 0", core_hold, done); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL count0_ready: got %b required 0", in_ready); end
    checks++; if (wr_addr.size() - base !== 0) begin fails++; $display("FAIL count0_nowrite: got %0d required 0", wr_addr.size() - base); end
    do_reset();
    base = wr_addr.size();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h41, 1'b0);
    in_data  = 8'h12;
    in_valid = 1'b1;
    repeat (8) @(negedge clock);
    settle(2);
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL count65_error: got %b required 1", error); end
    checks++; if (wr_addr.size() - base !== 0) begin fails++; $display("FAIL count65_nowrite: got %0d required 0", wr_addr.size() - base); end
    $display("test_bad_count: error=%b hold=%b", error, core_hold);
  endtask

  task automatic test_max_count();
    int base, n;
    do_reset();
    base = wr_addr.size();
    for (int i = 0; i < 64; i++) wv[i] = {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)};
    send_frame(64, wv, 1'b0);
    settle(3);
    n = wr_addr.size() - base;
    checks++; if (n !== 64) begin fails++; $display("FAIL max_nwrites: got %0d required 64", n); end
    if (n >= 64) begin
      checks++; if (wr_data[base] !== 32'h0001_0203) begin fails++; $display("FAIL max_first: got %h required 00010203", wr_data[base]); end
      checks++; if (wr_addr[base+63] !== 32'h0000_00FC || wr_data[base+63] !== 32'h3F40_4142) begin fails++; $display("FAIL max_last: got %h/%h required 000000fc/3f404142", wr_addr[base+63], wr_data[base+63]); end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL max_done: done=%b error=%b required 1 0", done, error); end
    $display("test_max_count: writes=%0d done=%b", n, done);
  endtask

  task automatic test_gaps();
    int base, n, dbl0;
    do_reset();
    base  = wr_addr.size();
    dbl0  = dbl_pulse;
    wv[0] = 32'h0123_4567;
    wv[1] = 32'h89AB_CDEF;
    wv[2] = 32'h0F1E_2D3C;
    send_frame(3, wv, 1'b1);
    settle(3);
    n = wr_addr.size() - base;
    checks++; if (n !== 3) begin fails++; $display("FAIL gaps_nwrites: got %0d required 3", n); end
    if (n >= 3) begin
      checks++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h0123_4567) begin fails++; $display("FAIL gaps_w0: got %h/%h required 00000000/01234567", wr_addr[base], wr_data[base]); end
      checks++; if (wr_addr[base+1] !== 32'h4 || wr_data[base+1] !== 32'h89AB_CDEF) begin fails++; $display("FAIL gaps_w1: got %h/%h required 00000004/89abcdef", wr_addr[base+1], wr_data[base+1]); end
      checks++; if (wr_addr[base+2] !== 32'h8 || wr_data[base+2] !== 32'h0F1E_2D3C) begin fails++; $display("FAIL gaps_w2: got %h/%h required 00000008/0f1e2d3c", wr_addr[base+2], wr_data[base+2]); end
    end
    checks++; if (dbl_pulse - dbl0 !== 0) begin fails++; $display("FAIL gaps_single_pulse: got %0d long pulses required 0", dbl_pulse - dbl0); end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL gaps_done: got %b required 1", done); end
    $display("test_gaps: writes=%0d done=%b", n, done);
  endtask

  task automatic test_midframe_reset();
    int base, n;
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || imem_we !== 1'b0) begin fails++; $display("FAIL async_reset_bus: ready=%b we=%b required 1 0", in_ready, imem_we); end
    checks++; if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL async_reset_status: hold=%b done=%b error=%b required 1 0 0", core_hold, done, error); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    base  = wr_addr.size();
    wv[0] = 32'hCAFE_BABE;
    send_frame(1, wv, 1'b0);
    settle(3);
    n = wr_addr.size() - base;
    checks++; if (n !== 1) begin fails++; $display("FAIL midreset_nwrites: got %0d required 1", n); end
    if (n >= 1) begin
      checks++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'hCAFE_BABE) begin fails++; $display("FAIL midreset_write: got %h/%h required 00000000/cafebabe", wr_addr[base], wr_data[base]); end
    end
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL midreset_done: got %b required 1", done); end
    $display("test_midframe_reset: writes=%0d done=%b", n, done);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int base, n;
    logic [7:0] fr [7];
    fr = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    do_reset();
    base = wr_addr.size();
    for (int i = 0; i < 7; i++) send_byte(fr[i], 1'b0);
    settle(3);
    n = wr_addr.size() - base;
    checks++; if (n !== 1) begin fails++; $display("FAIL csum_nwrites: got %0d required 1", n); end
    if (n >= 1) begin
      checks++; if (wr_addr[base] !== 32'h0 || wr_data[base] !== 32'h1234_5678) begin fails++; $display("FAIL csum_write: got %h/%h required 00000000/12345678", wr_addr[base], wr_data[base]); end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL csum_done: done=%b error=%b required 1 0", done, error); end
    fr[6] = 8'h09;
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(fr[i], 1'b0);
    settle(3);
    checks++; if (error !== 1'b1 || core_hold !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL csum_bad: error=%b hold=%b done=%b required 1 1 0", error, core_hold, done); end
    $display("test_checksum: error=%b hold=%b", error, core_hold);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_discard();
    test_bad_count();
    test_max_count();
    test_gaps();
    test_midframe_reset();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
